// File: rtl/counter_bank.sv
// rtl/counter_bank.sv - bank of CHANNELS independent WIDTH-bit up/down counters on one command port
// Optional: define COUNTER_BANK_SATURATE_EN to make Up/Down saturate at the ends instead of wrapping.
module counter_bank #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned SEL_W    = 1
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      En,
    input  logic [SEL_W-1:0]          Slt,
    input  logic [1:0]                Mode,
    input  logic [WIDTH-1:0]          LoadVal,
    input  logic [CHANNELS-1:0]       WrapClr,
    output logic [CHANNELS*WIDTH-1:0] Count,
    output logic [WIDTH-1:0]          SelCount,
    output logic [CHANNELS-1:0]       Wrap,
    output logic                      Err
);

    localparam logic [1:0] MODE_UP    = 2'b00;
    localparam logic [1:0] MODE_DOWN  = 2'b01;
    localparam logic [1:0] MODE_LOAD  = 2'b10;
    localparam logic [1:0] MODE_CLEAR = 2'b11;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0]    count_q [CHANNELS];
    logic [WIDTH-1:0]    count_d [CHANNELS];
    logic [CHANNELS-1:0] wrap_q;
    logic [CHANNELS-1:0] wrap_d;
    logic [CHANNELS-1:0] wrap_set;
    logic                err_q;
    logic                err_d;

    logic [31:0] slt_ext;
    logic        in_range;

    // Slt is widened so the range check stays correct when 2^SEL_W exceeds CHANNELS.
    assign slt_ext  = 32'(Slt);
    assign in_range = (slt_ext < CHANNELS);

    always_comb begin
        wrap_set = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            count_d[i] = count_q[i];
            if (En && in_range && (slt_ext == 32'(i))) begin
                case (Mode)
                    MODE_UP: begin
                        if (count_q[i] == ALL_ONES) begin
                            wrap_set[i] = 1'b1;
`ifdef COUNTER_BANK_SATURATE_EN
                            count_d[i]  = ALL_ONES;
`else
                            count_d[i]  = '0;
`endif
                        end else begin
                            count_d[i] = count_q[i] + ONE;
                        end
                    end
                    MODE_DOWN: begin
                        if (count_q[i] == '0) begin
                            wrap_set[i] = 1'b1;
`ifdef COUNTER_BANK_SATURATE_EN
                            count_d[i]  = '0;
`else
                            count_d[i]  = ALL_ONES;
`endif
                        end else begin
                            count_d[i] = count_q[i] - ONE;
                        end
                    end
                    MODE_LOAD:  count_d[i] = LoadVal;
                    MODE_CLEAR: count_d[i] = '0;
                    default:    count_d[i] = count_q[i];
                endcase
            end
        end
    end

    // A wrap event in the same cycle as its clear leaves the flag set.
    always_comb begin
        wrap_d = (wrap_q & ~WrapClr) | wrap_set;
        err_d  = En && !in_range;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                count_q[i] <= '0;
            end
            wrap_q <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                count_q[i] <= count_d[i];
            end
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        Count    = '0;
        SelCount = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            Count[i*WIDTH +: WIDTH] = count_q[i];
            if (in_range && (slt_ext == 32'(i))) begin
                SelCount = count_q[i];
            end
        end
    end

    assign Wrap = wrap_q;
    assign Err  = err_q;

endmodule

// File: tb/tb_counter_bank.sv
// tb/tb_counter_bank.sv - scoreboard bench for counter_bank with a queue-fed monitor and random stimulus
module tb_counter_bank;

    localparam int W    = 8;
    localparam int C    = 3;
    localparam int S    = 2;
    localparam int MAXV = (1 << W) - 1;

    logic           Clk = 1'b0;
    logic           Reset_n;
    logic           En;
    logic [S-1:0]   Slt;
    logic [1:0]     Mode;
    logic [W-1:0]   LoadVal;
    logic [C-1:0]   WrapClr;
    logic [C*W-1:0] Count;
    logic [W-1:0]   SelCount;
    logic [C-1:0]   Wrap;
    logic           Err;

    always #5 Clk = ~Clk;

    counter_bank #(.WIDTH(W), .CHANNELS(C), .SEL_W(S)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .En(En), .Slt(Slt), .Mode(Mode),
        .LoadVal(LoadVal), .WrapClr(WrapClr), .Count(Count),
        .SelCount(SelCount), .Wrap(Wrap), .Err(Err)
    );

    typedef struct {
        logic [C*W-1:0] count;
        logic [C-1:0]   wrap;
        logic           err;
    } exp_t;

    exp_t exp_q[$];
    int   m_cnt[C];
    bit   m_wrap[C];
    int   tests = 0;
    int   fails = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic logic [C*W-1:0] model_count();
        logic [C*W-1:0] p;
        for (int i = 0; i < C; i++) p[i*W +: W] = W'(m_cnt[i]);
        return p;
    endfunction

    function automatic logic [C-1:0] model_wrap();
        logic [C-1:0] p;
        for (int i = 0; i < C; i++) p[i] = m_wrap[i];
        return p;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < C; i++) begin
            m_cnt[i]  = 0;
            m_wrap[i] = 0;
        end
    endfunction

    task automatic cmd(input bit en, input int slt, input int mode, input int ld, input logic [C-1:0] clr);
        exp_t e;
        bit   set[C];
        @(negedge Clk);
        En = en; Slt = S'(slt); Mode = 2'(mode); LoadVal = W'(ld); WrapClr = clr;
        #1;
        chk("selcount", 64'(SelCount), (slt < C) ? 64'(m_cnt[slt]) : 64'd0);
        for (int i = 0; i < C; i++) set[i] = 0;
        if (en && slt < C) begin
            case (mode)
                0: if (m_cnt[slt] == MAXV) begin
                       set[slt] = 1;
`ifdef COUNTER_BANK_SATURATE_EN
                       m_cnt[slt] = MAXV;
`else
                       m_cnt[slt] = 0;
`endif
                   end else m_cnt[slt] = m_cnt[slt] + 1;
                1: if (m_cnt[slt] == 0) begin
                       set[slt] = 1;
`ifdef COUNTER_BANK_SATURATE_EN
                       m_cnt[slt] = 0;
`else
                       m_cnt[slt] = MAXV;
`endif
                   end else m_cnt[slt] = m_cnt[slt] - 1;
                2: m_cnt[slt] = ld & MAXV;
                default: m_cnt[slt] = 0;
            endcase
        end
        for (int i = 0; i < C; i++) m_wrap[i] = (m_wrap[i] && !clr[i]) || set[i];
        e.count = model_count();
        e.wrap  = model_wrap();
        e.err   = en && (slt >= C);
        exp_q.push_back(e);
    endtask

    task automatic idle();
        cmd(0, 0, 0, 0, '0);
    endtask

    task automatic reset_mid_cycle();
        @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        En = 1'b0;
        WrapClr = '0;
        #1;
        chk("reset_count", 64'(Count), 64'd0);
        chk("reset_wrap", 64'(Wrap), 64'd0);
        chk("reset_err", 64'(Err), 64'd0);
        model_reset();
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("count", 64'(Count), 64'(e.count));
                chk("wrap", 64'(Wrap), 64'(e.wrap));
                chk("err", 64'(Err), 64'(e.err));
            end
        end
    end

    initial begin : driver
        int slt, mode, ld, wait_cycles;
        logic [C-1:0] clr;
        Reset_n = 1'b0; En = 1'b0; Slt = '0; Mode = '0; LoadVal = '0; WrapClr = '0;
        model_reset();
        #12;
        chk("init_count", 64'(Count), 64'd0);
        chk("init_wrap", 64'(Wrap), 64'd0);
        chk("init_err", 64'(Err), 64'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        repeat (5) cmd(1, 0, 0, 0, '0);
        reset_mid_cycle();

        repeat (10) cmd(1, 1, 0, 0, '0);
        cmd(0, 1, 0, 0, '0);
        chk("ch1_is_10", 64'(m_cnt[1]), 64'd10);

        cmd(1, 2, 2, 'hFE, '0);
        cmd(1, 2, 0, 0, '0);
        cmd(1, 2, 0, 0, '0);
        cmd(1, 2, 1, 0, '0);
        cmd(0, 2, 0, 0, 3'b100);
        idle();

        cmd(1, 0, 3, 0, '0);
        cmd(1, 0, 1, 0, 3'b001);
        idle();

        cmd(1, 3, 0, 0, '0);
        idle();
        idle();

        cmd(1, 0, 2, 'hFF, '0);
        cmd(1, 0, 0, 0, '0);
        cmd(1, 0, 3, 0, '0);
        cmd(1, 0, 1, 0, '0);
        idle();

        for (int n = 0; n < 400; n++) begin
            slt  = $urandom_range(0, 3);
            mode = $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0: ld = 'hFF;
                1: ld = 'hFE;
                2: ld = 0;
                default: ld = $urandom_range(0, MAXV);
            endcase
            clr = ($urandom_range(0, 3) == 0) ? C'($urandom) : '0;
            cmd($urandom_range(0, 3) != 0, slt, mode, ld, clr);
            if (n == 200) reset_mid_cycle();
        end
        idle();

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge Clk);
            wait_cycles++;
        end
        #2;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
